// File: rtl/sseg_pkg.sv
// Shared types, constants and the segment table for the 4-digit
// seven-segment scan controller.
package sseg_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Native width of the segment table (gfedcba)
    localparam int SEG_W = 7;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // One complete display image: four digits, decimal points, digit enables
    typedef struct packed {
        logic [3:0][3:0] hex;
        logic [3:0]      dp;
        logic [3:0]      den;
    } disp_cfg_t;

    // Image held after reset: all zeros, no decimal points, all digits enabled
    localparam disp_cfg_t CFG_RESET = '{hex: 16'h0000, dp: 4'h0, den: 4'hF};

    // Next digit index, wrapping 3 -> 0
    function automatic logic [1:0] sel_inc(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational 4-bit hex to active-low segment decoder. Bits beyond
// the seven native segments are driven off.
module hex_to_sseg
    import sseg_pkg::*;
#(
    parameter int N = 7
) (
    input  logic [3:0]   hex,
    output logic [N-1:0] seg
);

    logic [SEG_W-1:0] tbl_s;

    assign tbl_s = SEG_TABLE[hex];

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i < SEG_W) begin : g_seg
            assign seg[i] = tbl_s[i];
        end else begin : g_pad
            assign seg[i] = 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller. Each digit gets a
// dark anti-ghosting gap followed by a lit dwell; new display images are
// staged and only committed at a frame boundary (or while idle) so a frame
// never mixes old and new values. All outputs come straight from flops.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N           = 7,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         load,
    input  logic [3:0]   hex0,
    input  logic [3:0]   hex1,
    input  logic [3:0]   hex2,
    input  logic [3:0]   hex3,
    input  logic [3:0]   dp_in,
    input  logic [3:0]   digit_en,
    output logic [1:0]   sel,
    output logic [3:0]   an,
    output logic [N-1:0] sseg,
    output logic         dp,
    output logic         frame_done
);

    localparam int MAX_DWELL = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW        = (MAX_DWELL < 1) ? 1 : $clog2(MAX_DWELL + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'((REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit SKIP_BLANK = (BLANK_CYC == 0);

    scan_state_t state_r, state_nxt_s;
    logic [1:0]    sel_r, sel_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          wrap_s;

    disp_cfg_t     stage_r, shadow_r, shadow_nxt_s, in_cfg_s;
    logic          pend_r, pend_nxt_s, upd_s;

    logic [3:0]    dig_hex_s;
    logic [N-1:0]  seg_dec_s;
    logic          lit_s;

    logic [3:0]    an_r, an_nxt_s;
    logic [N-1:0]  sseg_r, sseg_nxt_s;
    logic          dp_r, dp_nxt_s;
    logic          frame_done_r;

    // Next state, digit index and dwell count; flags the 3->0 wrap
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        cnt_nxt_s   = cnt_r;
        wrap_s      = 1'b0;
        if (!en) begin
            state_nxt_s = IDLE;
            sel_nxt_s   = 2'd0;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    sel_nxt_s   = 2'd0;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = SKIP_BLANK ? SHOW : BLANK;
                end
                BLANK: begin
                    if (cnt_r >= BLANK_LAST) begin
                        state_nxt_s = SHOW;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt_r >= SHOW_LAST) begin
                        state_nxt_s = SKIP_BLANK ? SHOW : BLANK;
                        sel_nxt_s   = sel_inc(sel_r);
                        cnt_nxt_s   = {CW{1'b0}};
                        wrap_s      = (sel_r == 2'd3);
                    end else begin
                        cnt_nxt_s   = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    sel_nxt_s   = 2'd0;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Commit a pending or coincident load at the frame boundary or while idle
    always_comb begin
        in_cfg_s     = '{hex: {hex3, hex2, hex1, hex0}, dp: dp_in, den: digit_en};
        upd_s        = (load || pend_r) &&
                       (frame_done_r || (state_r == IDLE) || (state_nxt_s == IDLE));
        shadow_nxt_s = shadow_r;
        pend_nxt_s   = pend_r;
        if (upd_s) begin
            shadow_nxt_s = load ? in_cfg_s : stage_r;
            pend_nxt_s   = 1'b0;
        end else if (load) begin
            pend_nxt_s   = 1'b1;
        end else begin
            pend_nxt_s   = pend_r;
        end
    end

    // Pick the digit value that will be on display next cycle
    always_comb begin
        dig_hex_s = shadow_nxt_s.hex[sel_nxt_s];
    end

    hex_to_sseg #(.N(N)) u_hex_to_sseg (
        .hex (dig_hex_s),
        .seg (seg_dec_s)
    );

    // Next-cycle drive values; dark unless showing an enabled digit
    always_comb begin
        lit_s      = (state_nxt_s == SHOW) && shadow_nxt_s.den[sel_nxt_s];
        an_nxt_s   = 4'b1111;
        sseg_nxt_s = {N{1'b1}};
        dp_nxt_s   = 1'b1;
        if (lit_s) begin
            an_nxt_s   = ~(4'b0001 << sel_nxt_s);
            sseg_nxt_s = seg_dec_s;
            dp_nxt_s   = ~shadow_nxt_s.dp[sel_nxt_s];
        end else begin
            an_nxt_s   = 4'b1111;
            sseg_nxt_s = {N{1'b1}};
            dp_nxt_s   = 1'b1;
        end
    end

    // Scan FSM, dwell counter and digit index registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            sel_r   <= 2'd0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Staging, shadow and pending-load registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_r  <= CFG_RESET;
            shadow_r <= CFG_RESET;
            pend_r   <= 1'b0;
        end else begin
            if (load) begin
                stage_r <= in_cfg_s;
            end else begin
                stage_r <= stage_r;
            end
            shadow_r <= shadow_nxt_s;
            pend_r   <= pend_nxt_s;
        end
    end

    // Output drive registers; reset darkens the display immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r         <= 4'b1111;
            sseg_r       <= {N{1'b1}};
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_nxt_s;
            sseg_r       <= sseg_nxt_s;
            dp_r         <= dp_nxt_s;
            frame_done_r <= wrap_s;
        end
    end

    assign sel        = sel_r;
    assign an         = an_r;
    assign sseg       = sseg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed self-checking bench for sseg_scan_ctrl with REFRESH_DIV=4 and
// BLANK_CYC=2 (24-cycle frame). Outputs are sampled on the falling edge.
module tb_sseg_scan_ctrl;

    localparam int N  = 7;
    localparam int RD = 4;
    localparam int BC = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         en;
    logic         load;
    logic [3:0]   hex0, hex1, hex2, hex3;
    logic [3:0]   dp_in;
    logic [3:0]   digit_en;
    logic [1:0]   sel;
    logic [3:0]   an;
    logic [N-1:0] sseg;
    logic         dp;
    logic         frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.N(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .sel        (sel),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_sel, input logic [3:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp, input logic e_fd);
        chk({tag, " sel"}, 32'(sel), 32'(e_sel));
        chk({tag, " an"}, 32'(an), 32'(e_an));
        chk({tag, " sseg"}, 32'(sseg), 32'(e_seg));
        chk({tag, " dp"}, 32'(dp), 32'(e_dp));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(e_fd));
    endtask

    // One digit slot: BC dark cycles then RD lit cycles; load pulsed in cycle ld_idx
    task automatic check_slot(input logic [1:0] s, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp, input logic fd_first, input int ld_idx);
        for (int i = 0; i < BC + RD; i++) begin
            step();
            if (i < BC)
                check_out($sformatf("s%0d c%0d", s, i), s, 4'hF, 7'h7F, 1'b1,
                          (i == 0) ? fd_first : 1'b0);
            else
                check_out($sformatf("s%0d c%0d", s, i), s, e_an, e_seg, e_dp, 1'b0);
            load = (i == ld_idx);
        end
    endtask

    task automatic set_in(input logic [3:0] h3, input logic [3:0] h2, input logic [3:0] h1,
                          input logic [3:0] h0, input logic [3:0] dpv, input logic [3:0] denv);
        hex3 = h3; hex2 = h2; hex1 = h1; hex0 = h0;
        dp_in = dpv; digit_en = denv;
    endtask

    initial begin
        reset_n = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
        #2 reset_n = 1'b0;
        step();
        step();
        check_out("reset", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);

        reset_n = 1'b1;
        step();
        check_out("idle", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);

        // Load 3210 while idle, then enable scanning
        set_in(4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'hF);
        load = 1'b1;
        step();
        load = 1'b0;
        check_out("idle load", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);
        en = 1'b1;

        // Frame 1: 3210, no frame_done at its start
        check_slot(2'd0, 4'b1110, 7'h40, 1'b1, 1'b0, -1);
        check_slot(2'd1, 4'b1101, 7'h79, 1'b1, 1'b0, -1);
        check_slot(2'd2, 4'b1011, 7'h24, 1'b1, 1'b0, -1);
        check_slot(2'd3, 4'b0111, 7'h30, 1'b1, 1'b0, -1);

        // Frame 2: load 8888 mid-digit-1, remaining digits keep old values
        set_in(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'hF);
        check_slot(2'd0, 4'b1110, 7'h40, 1'b1, 1'b1, -1);
        check_slot(2'd1, 4'b1101, 7'h79, 1'b1, 1'b0, 3);
        check_slot(2'd2, 4'b1011, 7'h24, 1'b1, 1'b0, -1);
        check_slot(2'd3, 4'b0111, 7'h30, 1'b1, 1'b0, -1);

        // Frame 3: 8888; stage 3210 with digit 2 disabled and dp on digit 0
        set_in(4'h3, 4'h2, 4'h1, 4'h0, 4'b0001, 4'b1011);
        check_slot(2'd0, 4'b1110, 7'h00, 1'b1, 1'b1, 3);
        check_slot(2'd1, 4'b1101, 7'h00, 1'b1, 1'b0, -1);
        check_slot(2'd2, 4'b1011, 7'h00, 1'b1, 1'b0, -1);
        check_slot(2'd3, 4'b0111, 7'h00, 1'b1, 1'b0, -1);

        // Frame 4: digit 2 blanked in its slot, dp lit only on digit 0
        check_slot(2'd0, 4'b1110, 7'h40, 1'b0, 1'b1, -1);
        check_slot(2'd1, 4'b1101, 7'h79, 1'b1, 1'b0, -1);
        check_slot(2'd2, 4'b1111, 7'h7F, 1'b1, 1'b0, -1);
        check_slot(2'd3, 4'b0111, 7'h30, 1'b1, 1'b0, -1);

        // Frame 5: load FEDC on the frame_done cycle, shown from this frame's digit 0
        set_in(4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'hF);
        check_slot(2'd0, 4'b1110, 7'h46, 1'b1, 1'b1, 0);
        check_slot(2'd1, 4'b1101, 7'h21, 1'b1, 1'b0, -1);

        // Drop en during BLANK of digit 2
        step();
        check_out("s2 blank", 2'd2, 4'hF, 7'h7F, 1'b1, 1'b0);
        en = 1'b0;
        step();
        check_out("en drop", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        check_out("en low", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);

        // Load 9754 while idle together with re-enable
        set_in(4'h9, 4'h7, 4'h5, 4'h4, 4'h0, 4'hF);
        load = 1'b1;
        en   = 1'b1;
        check_slot(2'd0, 4'b1110, 7'h19, 1'b1, 1'b0, -1);
        check_slot(2'd1, 4'b1101, 7'h12, 1'b1, 1'b0, -1);
        check_slot(2'd2, 4'b1011, 7'h78, 1'b1, 1'b0, -1);
        check_slot(2'd3, 4'b0111, 7'h10, 1'b1, 1'b0, -1);

        // First frame_done 24 cycles after re-enable, then reset mid-SHOW
        step();
        check_out("f7 start", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b1);
        step();
        step();
        check_out("f7 show", 2'd0, 4'b1110, 7'h19, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_out("async reset", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_out("post reset blank", 2'd0, 4'hF, 7'h7F, 1'b1, 1'b0);
        step();
        step();
        check_out("post reset show", 2'd0, 4'b1110, 7'h40, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter N, default 7, is the segment bus width.
REQ-002 Parameter REFRESH_DIV, default 100000, is the number of clock cycles each digit is lit.
REQ-003 Parameter BLANK_CYC, default 4, is the number of all-anodes-off cycles before each digit (anti-ghosting).
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 en  input  1  enables scanning; when low, the display is dark.
REQ-007 load  input  1  is a single-cycle request to capture hex3..hex0, dp_in and digit_en into the shadow registers.
REQ-008 hex0, hex1, hex2, hex3  input  4 each  are the digit values, with hex0 as the rightmost digit.
REQ-009 dp_in  input  4  is the per-digit decimal point request, active-high.
REQ-010 digit_en  input  4  is the per-digit enable; a 0 blanks that digit while it keeps its time slot.
REQ-011 sel  output  2  is the current digit index.
REQ-012 an  output  4  is the anode drive, active-low.
REQ-013 sseg  output  N  is the segment drive in gfedcba order (bit 6 = g), active-low.
REQ-014 dp  output  1  is the decimal point drive, active-low.
REQ-015 frame_done  output  1  is a one-cycle pulse marking the end of each complete 4-digit frame.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, BLANK and SHOW.
REQ-017 All outputs SHALL be decoded from registered state and shadow registers only, with no combinational path from any input.
REQ-018 In IDLE: an=4'b1111, sseg all ones, dp=1, sel=0.
REQ-019 IDLE->BLANK when en=1; the first BLANK uses sel=0.
REQ-020 In BLANK: an=4'b1111, held for exactly BLANK_CYC cycles, then ->SHOW with the same sel; if BLANK_CYC=0, BLANK SHALL be skipped.
REQ-021 In SHOW: held for exactly REFRESH_DIV cycles, with an[sel]=0 only if the shadow digit_en[sel]=1.
REQ-022 In SHOW: sseg = decoded shadow hex[sel] and dp = ~shadow dp_in[sel].
REQ-023 When a digit is blanked, sseg and dp SHALL be all ones.
REQ-024 At the end of SHOW: sel SHALL become (sel+1) mod 4 and the FSM SHALL go ->BLANK.
REQ-025 When sel wraps 3->0, frame_done SHALL be 1 for exactly that one cycle.
REQ-026 Frame period = 4*(BLANK_CYC+REFRESH_DIV) cycles.
REQ-027 The dwell counter SHALL be ceil(log2(max(REFRESH_DIV,BLANK_CYC)+1)) bits wide, SHALL reload to 0 on every state change, and SHALL never wrap mid-state.
REQ-028 A load pulse SHALL set a pending flag, and the inputs SHALL be sampled into a staging register in the same cycle.
REQ-029 If load is repeated before the frame wrap, the last one SHALL win.
REQ-030 The staging register SHALL be copied to the shadow registers on the frame-wrap cycle (REQ-025), which clears the pending flag; a displayed frame therefore never mixes old and new values.
REQ-031 If load occurs while in IDLE, the shadow registers SHALL update on the next clock.
REQ-032 If load coincides with the frame-wrap cycle, the new values SHALL be taken at that same wrap.
REQ-033 If en falls in any state, the FSM SHALL go ->IDLE on the next edge, sel=0, the counter cleared and no frame_done.
REQ-034 A pending load SHALL be preserved when en falls and SHALL apply on entry to IDLE.
REQ-035 Hex decode SHALL cover all 16 values 0-F, e.g. 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110.

Reset
REQ-036 On reset_n=0 the block SHALL immediately, without waiting for clk, enter IDLE with: sel=0, an=4'b1111, sseg all ones, dp=1, frame_done=0, counter=0, pending=0, shadow/staging hex=0, dp=0 and digit_en=4'b1111.
REQ-037 Reset asserted mid-SHOW SHALL darken the display in the same cycle.
REQ-038 After reset_n rises, the first BLANK SHALL start on the first edge with en=1.

Structure
REQ-039 Package sseg_pkg SHALL hold the state enum (IDLE, BLANK, SHOW), the SEG_BLANK constant (all ones) and the 16-entry active-low segment table.
REQ-040 One sub-module, hex_to_sseg, SHALL be a combinational 4-bit to N-bit active-low decoder using the package table.
REQ-041 The FSM, counter, shadow registers and staging registers SHALL live in sseg_scan_ctrl.

Verification (REFRESH_DIV=4, BLANK_CYC=2)
REQ-042 Assert reset_n=0 mid-SHOW -> same cycle an=1111, sseg=1111111, dp=1, sel=0, frame_done=0.
REQ-043 load with hex3..0=3,2,1,0 and en=1 -> sel 0: 2 cycles an=1111, then 4 cycles an=1110 with sseg=1000000; sel then steps 1,2,3; frame_done pulses every 24 cycles.
REQ-044 Frame showing 3210, load 8888 mid-digit-1 -> digits 1-3 still show 3,2,1; the first 8 (sseg=0000000) appears in the SHOW following frame_done.
REQ-045 digit_en=4'b1011, dp_in=4'b0001 -> an[2] never 0 and slot timing unchanged; dp=0 only during SHOW of sel=0.
REQ-046 en dropped during BLANK of sel=2 -> next cycle IDLE with an=1111; en re-asserted -> BLANK with sel=0, and no frame_done until a full 24 cycles later.
REQ-047 load asserted on the frame-wrap cycle, and load asserted while IDLE -> new values shown starting at the next sel=0 SHOW; no mixed frame.
